// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: funct3 codes,
// FSM state encoding, default timeout and the request legality check.
package lsu_pkg;

  localparam int TIMEOUT_DEF = 15;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Returns 1 when a request must be rejected without touching memory:
  // misaligned halfword/word, unknown load width, or store width other than B/H/W.
  function automatic logic req_bad(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = off[0];
      F3_HU:   bad = we | off[0];
      F3_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data for
// the outgoing request, and lane selection plus sign/zero extension of load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and halfword out of the loaded word.
  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    case (offset)
      2'b00:   lane_b = rword[7:0];
      2'b01:   lane_b = rword[15:8];
      2'b10:   lane_b = rword[23:16];
      2'b11:   lane_b = rword[31:24];
      default: lane_b = 8'h00;
    endcase
    if (offset[1]) begin
      lane_h = rword[31:16];
    end else begin
      lane_h = rword[15:0];
    end
  end

  // Width-dependent enables, store replication and load extension.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    rdata_ext = 32'h0000_0000;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane_b[7]}}, lane_b};
      end
      F3_BU: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h000000, lane_b};
      end
      F3_H: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{lane_h[15]}}, lane_h};
      end
      F3_HU: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0000, lane_h};
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        rdata_ext = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between an RV32I core and a
// req/gnt/rvalid memory port. All outputs are registered in the FSM block.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wd,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rd
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  lsu_state_e    state;
  logic          we_r;
  logic [2:0]    funct3_r;
  logic [1:0]    off_r;
  logic [CW-1:0] cnt;

  logic [2:0]    al_funct3;
  logic [1:0]    al_off;
  logic [31:0]   al_wdata;
  logic [3:0]    al_be;
  logic [31:0]   al_wd;
  logic [31:0]   al_rdata;
  logic          hs;
  logic          bad;

  // The aligner sees the live request while idle, the captured fields otherwise.
  always_comb begin
    al_funct3 = funct3_r;
    al_off    = off_r;
    al_wdata  = 32'h0000_0000;
    if (state == ST_IDLE) begin
      al_funct3 = req_funct3;
      al_off    = req_addr[1:0];
      al_wdata  = req_wdata;
    end else begin
      al_funct3 = funct3_r;
      al_off    = off_r;
      al_wdata  = 32'h0000_0000;
    end
  end

  assign hs  = req_valid & req_ready;
  assign bad = req_bad(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3    (al_funct3),
    .offset    (al_off),
    .wdata     (al_wdata),
    .rword     (mem_rd),
    .be        (al_be),
    .wdata_rep (al_wd),
    .rdata_ext (al_rdata)
  );

  // Main FSM: accepts a request, drives the memory port, waits for data,
  // enforces the ISSUE+WAIT cycle budget and emits the one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_be     <= 4'b0000;
      mem_wd     <= 32'h0000_0000;
      cnt        <= '0;
      we_r       <= 1'b0;
      funct3_r   <= 3'b000;
      off_r      <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            req_ready <= 1'b0;
            we_r      <= req_we;
            funct3_r  <= req_funct3;
            off_r     <= req_addr[1:0];
            if (bad) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else begin
              state    <= ST_ISSUE;
              mem_req  <= 1'b1;
              mem_we   <= req_we;
              mem_addr <= {req_addr[31:2], 2'b00};
              mem_be   <= al_be;
              mem_wd   <= req_we ? al_wd : 32'h0000_0000;
              cnt      <= CW'(1);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // A grant that finishes a store wins over the budget; a load grant
          // on the last budget cycle still aborts since data cannot arrive in time.
          if (mem_gnt && we_r) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wd     <= 32'h0000_0000;
            cnt        <= '0;
          end else if (cnt == TO_V) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0000_0000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wd     <= 32'h0000_0000;
            cnt        <= '0;
          end else if (mem_gnt) begin
            state   <= ST_WAIT;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            mem_wd  <= 32'h0000_0000;
            cnt     <= cnt + CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= al_rdata;
            cnt        <= '0;
          end else if (cnt == TO_V) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0000_0000;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          cnt        <= '0;
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
          mem_be     <= 4'b0000;
          mem_wd     <= 32'h0000_0000;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: the driver pushes the expected response
// (data, error flag, arrival cycle) per request; a monitor pops on resp_valid.
module tb_lsu_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wd;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rd = 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wd     (mem_wd),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // One request plus memory-side behaviour. gnt_dly/rv_dly < 0 means never.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gnt_dly, input logic both,
                        input int rv_dly, input logic [31:0] rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    exp_t e;
    bit   mem_exp;
    bit   granted;
    int   w;
    mem_exp = !(exp_err && exp_lat == 1);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + exp_lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = 32'h0;
    if (!mem_exp) begin
      for (int i = 0; i < 2; i++) begin
        chk("no_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
      end
    end else begin
      granted = 1'b0;
      for (int k = 1; k <= TO && !granted; k++) begin
        chk("mem_req", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
        chk("mem_we", {31'd0, mem_we}, {31'd0, we});
        if (we) chk("mem_wd", mem_wd, exp_wd);
        if (gnt_dly >= 0 && k - 1 == gnt_dly) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
          if (both) begin
            mem_rvalid = 1'b1;
            mem_rd     = 32'hDEAD_BEEF;
          end
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rd     = 32'h0;
      end
      chk("mem_req_drop", {27'd0, mem_req, mem_be}, 32'd0);
      if (granted && !we && rv_dly >= 0) begin
        repeat (rv_dly) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rd     = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rd     = 32'h0;
      end
    end
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (sb.size() != 0) begin
      chk("resp_missing", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst_n is held low.
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp", {31'd0, resp_err} | resp_rdata, 32'd0);
    chk("rst_mem_ctl", {26'd0, mem_req, mem_we, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     we    f3      addr          wdata          gd  both rv  rd             be       wd             rdata          err  lat
    do_txn(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56A5, 0, 1'b0, 0, 32'h0,          4'b1000, 32'hA5A5_A5A5, 32'h0,          1'b0, 2);
    do_txn(1'b0, 3'b000, 32'h0000_0102, 32'h0,         0, 1'b0, 0, 32'h0080_0000,  4'b0100, 32'h0,         32'hFFFF_FF80,  1'b0, 3);
    do_txn(1'b0, 3'b100, 32'h0000_0102, 32'h0,         0, 1'b0, 0, 32'h0080_0000,  4'b0100, 32'h0,         32'h0000_0080,  1'b0, 3);
    do_txn(1'b0, 3'b010, 32'h0000_0202, 32'h0,         0, 1'b0, 0, 32'h0,          4'b0000, 32'h0,         32'h0,          1'b1, 1);
    do_txn(1'b0, 3'b001, 32'h0000_0010, 32'h0,         3, 1'b0, 1, 32'h1234_8001,  4'b0011, 32'h0,         32'hFFFF_8001,  1'b0, 7);
    do_txn(1'b0, 3'b101, 32'h0000_0012, 32'h0,         0, 1'b0, 0, 32'h8001_0000,  4'b1100, 32'h0,         32'h0000_8001,  1'b0, 3);
    do_txn(1'b1, 3'b001, 32'h0000_0006, 32'hCAFE_BEEF, 1, 1'b0, 0, 32'h0,          4'b1100, 32'hBEEF_BEEF, 32'h0,          1'b0, 3);
    do_txn(1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 0, 1'b0, 0, 32'h0,          4'b1111, 32'h1122_3344, 32'h0,          1'b0, 2);
    do_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0,         0, 1'b0, 2, 32'hCAFE_F00D,  4'b1111, 32'h0,         32'hCAFE_F00D,  1'b0, 5);
    do_txn(1'b0, 3'b000, 32'h0000_0041, 32'h0,         0, 1'b0, 0, 32'h0000_7F00,  4'b0010, 32'h0,         32'h0000_007F,  1'b0, 3);
    do_txn(1'b1, 3'b011, 32'h0000_0000, 32'h0,         0, 1'b0, 0, 32'h0,          4'b0000, 32'h0,         32'h0,          1'b1, 1);
    do_txn(1'b0, 3'b110, 32'h0000_0000, 32'h0,         0, 1'b0, 0, 32'h0,          4'b0000, 32'h0,         32'h0,          1'b1, 1);
    do_txn(1'b1, 3'b001, 32'h0000_0101, 32'h0,         0, 1'b0, 0, 32'h0,          4'b0000, 32'h0,         32'h0,          1'b1, 1);
    do_txn(1'b0, 3'b101, 32'h0000_0103, 32'h0,         0, 1'b0, 0, 32'h0,          4'b0000, 32'h0,         32'h0,          1'b1, 1);
    do_txn(1'b1, 3'b100, 32'h0000_0000, 32'h0,         0, 1'b0, 0, 32'h0,          4'b0000, 32'h0,         32'h0,          1'b1, 1);
    // gnt and rvalid together in ISSUE: only the grant counts.
    do_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0,         0, 1'b1, 0, 32'h0BAD_F00D,  4'b1111, 32'h0,         32'h0BAD_F00D,  1'b0, 3);
    // Timeouts: load granted but no data; store never granted.
    do_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0,         0, 1'b0, -1, 32'h0,         4'b1111, 32'h0,         32'h0,          1'b1, TO + 1);
    do_txn(1'b1, 3'b010, 32'h0000_0600, 32'h5555_AAAA, -1, 1'b0, -1, 32'h0,        4'b1111, 32'h5555_AAAA, 32'h0,          1'b1, TO + 1);

    // Reset while a load waits for data: no response, outputs cleared at once.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0700;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_pre_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_mem", {27'd0, mem_req, mem_be}, 32'd0);
    chk("rstw_mem_addr", mem_addr, 32'd0);
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rd     = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rd     = 32'h0;
    rst_n      = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstw_idle_mem_req", {31'd0, mem_req}, 32'd0);
    do_txn(1'b1, 3'b000, 32'h0000_0000, 32'h0000_005A, 0, 1'b0, 0, 32'h0,          4'b0001, 32'h5A5A_5A5A, 32'h0,          1'b0, 2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
